// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared serial slave bus.
// The granted master's serial outputs are broadcast to every slave. The
// arbiter snoops the start of the granted master's control frame
// (111 | slave ID | ...) to learn the target slave, then routes that
// slave's rD/ready back to the granted master only.
module serial_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int SLAVES      = 3,
  parameter int S_ID_WIDTH  = $clog2(SLAVES + 1),
  parameter int M_ID_WIDTH  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_grant,
  input  logic [NUM_MASTERS-1:0] m_control,
  input  logic [NUM_MASTERS-1:0] m_wD,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_last,
  output logic [NUM_MASTERS-1:0] m_rD,
  output logic [NUM_MASTERS-1:0] m_ready,
  output logic                   s_control,
  output logic                   s_wD,
  output logic                   s_valid,
  output logic                   s_last,
  input  logic [SLAVES-1:0]      s_rD,
  input  logic [SLAVES-1:0]      s_ready,
  output logic                   busy,
  output logic [M_ID_WIDTH-1:0]  cur_master,
  output logic                   hdr_err
);

  // Header = start bit + two more 1s + slave ID.
  localparam int HDR_LEN = 3 + S_ID_WIDTH;
  // Only the bits before the last one need storing; the last arrives live.
  localparam int SH_W    = HDR_LEN - 1;
  localparam int CNT_W   = $clog2(HDR_LEN + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HEADER,
    S_ROUTE,
    S_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [M_ID_WIDTH-1:0]  cur_q, cur_d;
  logic [M_ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [S_ID_WIDTH-1:0]  id_q, id_d;
  logic [SH_W-1:0]        shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic                   err_q, err_d;

  // Signals of the currently granted master (all zero when idle).
  logic                   g_req;
  logic                   g_ctrl;
  logic [HDR_LEN-1:0]     shifted;
  logic [S_ID_WIDTH-1:0]  hdr_id;
  logic                   hdr_ok;
  logic                   rr_found;
  logic [M_ID_WIDTH-1:0]  rr_idx;
  logic [M_ID_WIDTH-1:0]  rr_c;
  logic [M_ID_WIDTH-1:0]  ptr_next;
  logic                   do_release;
  logic                   sel_rd;
  logic                   sel_rdy;

  // The grant is one-hot, so AND-reduce-OR acts as the master mux.
  assign g_req     = |(m_req     & grant_q);
  assign g_ctrl    = |(m_control & grant_q);
  assign s_control = g_ctrl;
  assign s_wD      = |(m_wD      & grant_q);
  assign s_valid   = |(m_valid   & grant_q);
  assign s_last    = |(m_last    & grant_q);

  // Header as it would look after this cycle's control bit is shifted in.
  assign shifted = {shift_q, g_ctrl};
  assign hdr_id  = shifted[S_ID_WIDTH-1:0];
  assign hdr_ok  = (shifted[HDR_LEN-1 -: 3] == 3'b111) &&
                   (hdr_id != '0) &&
                   (hdr_id <= S_ID_WIDTH'(SLAVES));

  assign ptr_next = (cur_q == M_ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : cur_q + 1'b1;

  assign m_grant    = grant_q;
  assign busy       = |grant_q;
  assign cur_master = cur_q;
  assign hdr_err    = err_q;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // up front; a path that leaves one unassigned would infer a latch.
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_c     = ptr_q;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!rr_found && m_req[rr_c]) begin
        rr_found = 1'b1;
        rr_idx   = rr_c;
      end
      rr_c = (rr_c == M_ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : rr_c + 1'b1;
    end
  end

  // Return-path select; id_q is non-zero only after a valid header.
  always_comb begin
    sel_rd  = 1'b0;
    sel_rdy = 1'b0;
    for (int j = 0; j < SLAVES; j++) begin
      if (id_q == S_ID_WIDTH'(j + 1)) begin
        sel_rd  = s_rD[j];
        sel_rdy = s_ready[j];
      end
    end
  end

  assign m_rD    = grant_q & {NUM_MASTERS{sel_rd}};
  assign m_ready = grant_q & {NUM_MASTERS{sel_rdy}};

  // Next-state logic: grant, header snoop, timeout and release.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cur_d      = cur_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    err_d      = 1'b0;
    do_release = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          grant_d         = '0;
          grant_d[rr_idx] = 1'b1;
          cur_d           = rr_idx;
          id_d            = '0;
          to_d            = '0;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        if (g_ctrl) begin
          // The start bit is the first header bit.
          shift_d = SH_W'(1);
          cnt_d   = CNT_W'(1);
          state_d = S_HEADER;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          do_release = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_HEADER: begin
        shift_d = shifted[SH_W-1:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
          state_d = S_ROUTE;
          // A bad header leaves the ID at 0, so there is no return path.
          if (hdr_ok) id_d  = hdr_id;
          else        err_d = 1'b1;
        end
      end
      S_ROUTE: begin
        // Frame body is passed through untouched.
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Dropping the request ends the transaction from any active state.
    if ((state_q == S_WAIT || state_q == S_HEADER || state_q == S_ROUTE) && !g_req)
      do_release = 1'b1;

    if (do_release) begin
      grant_d = '0;
      cur_d   = '0;
      id_d    = '0;
      ptr_d   = ptr_next;
      err_d   = 1'b0;
      state_d = S_RELEASE;
    end
  end

  // State registers; the asynchronous reset drops the grant immediately.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      cur_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      grant_q <= grant_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

endmodule
